// File: rtl/pc_gen_pkg.sv
// Shared encodings for the PIC16C5x program-counter generator: control-flow
// request codes, return-stack commands and target-address helpers.
package pc_gen_pkg;

  localparam int unsigned PC_WIDTH_DEF = 11;

  // Control-flow request from the decoder.
  localparam logic [2:0] PC_OP_NEXT  = 3'd0;
  localparam logic [2:0] PC_OP_GOTO  = 3'd1;
  localparam logic [2:0] PC_OP_CALL  = 3'd2;
  localparam logic [2:0] PC_OP_RET   = 3'd3;
  localparam logic [2:0] PC_OP_WRPCL = 3'd4;
  localparam logic [2:0] PC_OP_SKIP  = 3'd5;

  // Return-stack command, shared with the stack block.
  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  // Every op except NEXT (and the unused codes) redirects fetch and flushes.
  function automatic logic is_taken(input logic [2:0] op);
    return op inside {PC_OP_GOTO, PC_OP_CALL, PC_OP_RET, PC_OP_WRPCL, PC_OP_SKIP};
  endfunction

  // Paged 11-bit target: STATUS page bits above a 9-bit in-page offset.
  function automatic logic [10:0] page_target(input logic [1:0] pa, input logic [8:0] offset);
    return {pa, offset};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/stack bundle between pc_gen, the decoder, program memory and the
// 2-level return stack.
interface pc_gen_if #(
    parameter int PC_WIDTH = 11
) ();

    logic                en;
    logic [2:0]          pc_op;
    logic [8:0]          k;
    logic [1:0]          pa;
    logic [7:0]          pcl_data;
    logic [PC_WIDTH-1:0] stk_top;

    logic [PC_WIDTH-1:0] pc;
    logic                inst_valid;
    logic [1:0]          stk_cmd;
    logic [PC_WIDTH-1:0] stk_data;

    // pc_gen owns the fetch address and the stack command.
    modport master (
        input  en, pc_op, k, pa, pcl_data, stk_top,
        output pc, inst_valid, stk_cmd, stk_data
    );

    // Core side: decoder, STATUS, ALU and stack.
    modport slave (
        output en, pc_op, k, pa, pcl_data, stk_top,
        input  pc, inst_valid, stk_cmd, stk_data
    );

endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: fetch PC, next-PC selection, return-stack
// push/pop and the one-cycle flush after every taken control-flow op.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    logic [PC_WIDTH-1:0] pc_q;
    logic                valid_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [1:0]          stk_cmd;
    logic                honour;
    logic                taken;

    // A request counts only for a real instruction in an enabled, non-reset cycle.
    assign honour = bus.en & valid_q & ~rst;
    assign taken  = honour & is_taken(bus.pc_op);
    assign pc_inc = pc_q + PC_WIDTH'(1);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_next = pc_inc;
        stk_cmd = STK_NOP;
        if (honour) begin
            case (bus.pc_op)
                PC_OP_GOTO:  pc_next = PC_WIDTH'(page_target(bus.pa, bus.k));
                PC_OP_CALL: begin
                    pc_next = PC_WIDTH'(page_target(bus.pa, {1'b0, bus.k[7:0]}));
                    stk_cmd = STK_PUSH;
                end
                PC_OP_RET: begin
                    // stk_top is still the pre-pop value here; the pop lands on this edge.
                    pc_next = bus.stk_top;
                    stk_cmd = STK_POP;
                end
                PC_OP_WRPCL: pc_next = PC_WIDTH'(page_target(bus.pa, {1'b0, bus.pcl_data}));
                default:     pc_next = pc_inc;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            pc_q    <= pc_next;
            valid_q <= ~taken;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.stk_cmd    = stk_cmd;
    assign bus.stk_data   = pc_q;

    a_stack_quiet: assert property (@(posedge clk)
        (rst || !bus.en) |-> (bus.stk_cmd == STK_NOP));

    a_stall_holds: assert property (@(posedge clk) disable iff (rst)
        !bus.en |=> ($stable(pc_q) && $stable(valid_q)));

    a_flush_one_cycle: assert property (@(posedge clk) disable iff (rst)
        (bus.en && !valid_q) |=> valid_q);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed control-flow scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int W    = 11;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;

    pc_gen_if #(.PC_WIDTH(W)) bus ();

    pc_gen #(.PC_WIDTH(W), .RESET_VECTOR('1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural PC, valid flag and the 2-entry stack.
    int pc_m = 0, v_m = 0, pc_n = 0, v_n = 0;
    bit known = 0, pend = 0, rst_pend = 0;
    int stk_m [2] = '{0, 0};
    logic [1:0] cmd_n = STK_NOP;
    int push_val = 0;
    logic [1:0] last_cmd;
    int last_data;

    assign bus.stk_top = W'(stk_m[0]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit en, input bit r, input int op, input int kk,
                        input int p, input int pcl);
        int tgt;
        bit taken;
        bit hon;
        logic [1:0] cmd_e;
        @(negedge clk);
        if (pend) begin
            if (cmd_n == STK_PUSH) begin
                stk_m[1] = stk_m[0];
                stk_m[0] = push_val;
            end else if (cmd_n == STK_POP) begin
                stk_m[0] = stk_m[1];
            end
            pc_m = pc_n;
            v_m  = v_n;
            if (rst_pend) known = 1;
        end
        rst          = r;
        bus.en       = en;
        bus.pc_op    = 3'(op);
        bus.k        = 9'(kk);
        bus.pa       = 2'(p);
        bus.pcl_data = 8'(pcl);
        #1;
        hon   = en && (v_m != 0) && !r;
        taken = 0;
        tgt   = (pc_m + 1) & MASK;
        cmd_e = STK_NOP;
        if (hon) begin
            case (op)
                1: begin tgt = (p * 512 + kk) & MASK;         taken = 1; end
                2: begin tgt = (p * 512 + kk % 256) & MASK;   taken = 1; cmd_e = STK_PUSH; end
                3: begin tgt = stk_m[0];                      taken = 1; cmd_e = STK_POP; end
                4: begin tgt = (p * 512 + pcl) & MASK;        taken = 1; end
                5: begin                                      taken = 1; end
                default: ;
            endcase
        end
        last_cmd  = bus.stk_cmd;
        last_data = int'(bus.stk_data);
        check("stk_cmd", 32'(bus.stk_cmd), 32'(cmd_e));
        if (known) begin
            check("pc", 32'(bus.pc), 32'(pc_m));
            check("inst_valid", 32'(bus.inst_valid), 32'(v_m));
            check("stk_data", 32'(bus.stk_data), 32'(pc_m));
        end
        if (r) begin
            pc_n = MASK;
            v_n  = 0;
        end else if (en) begin
            pc_n = tgt;
            v_n  = taken ? 0 : 1;
        end else begin
            pc_n = pc_m;
            v_n  = v_m;
        end
        cmd_n    = cmd_e;
        push_val = pc_m;
        rst_pend = r;
        pend     = 1;
    endtask

    task automatic expect_state(input string tag, input int p, input int v);
        check({tag, "_pc"}, 32'(bus.pc), 32'(p));
        check({tag, "_valid"}, 32'(bus.inst_valid), 32'(v));
    endtask

    task automatic run_to(input int t);
        for (int n = 0; n <= 64; n++) begin
            if (pc_n == t && v_n == 1) break;
            if (n == 64) begin
                check("run_to_budget", 32'(pc_n), 32'(t));
                break;
            end
            step(1, 0, 0, 0, 0, 0);
        end
    endtask

    // Leaves the model positioned so the next step executes at fetch pc=t.
    task automatic goto_valid(input int t);
        int d;
        d = (t - 1) & MASK;
        step(1, 0, 1, d & 511, (d >> 9) & 3, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a CALL pending: no push may leak out.
        step(1, 1, 2, 9'h040, 0, 0);
        check("rst_cmd0", 32'(last_cmd), 32'(STK_NOP));
        step(1, 1, 2, 9'h040, 0, 0);
        expect_state("rst", 11'h7FF, 0);
        check("rst_cmd1", 32'(last_cmd), 32'(STK_NOP));

        step(1, 0, 0, 0, 0, 0); expect_state("seq0", 11'h7FF, 0);
        step(1, 0, 0, 0, 0, 0); expect_state("seq1", 11'h000, 1);
        step(1, 0, 0, 0, 0, 0); expect_state("seq2", 11'h001, 1);
        step(1, 0, 0, 0, 0, 0); expect_state("seq3", 11'h002, 1);

        run_to(11'h005);
        step(1, 0, 1, 9'h123, 2'b10, 0); expect_state("goto_at", 11'h005, 1);
        step(1, 0, 0, 0, 0, 0);          expect_state("goto_tgt", 11'h523, 0);
        step(1, 0, 0, 0, 0, 0);          expect_state("goto_nxt", 11'h524, 1);

        goto_valid(11'h011);
        step(1, 0, 2, 9'h040, 0, 0);     expect_state("call_at", 11'h011, 1);
        check("call_cmd", 32'(last_cmd), 32'(STK_PUSH));
        check("call_data", 32'(last_data), 32'h011);
        step(1, 0, 0, 0, 0, 0);          expect_state("call_tgt", 11'h040, 0);
        step(1, 0, 3, 0, 0, 0);          expect_state("ret_at", 11'h041, 1);
        check("ret_cmd", 32'(last_cmd), 32'(STK_POP));
        step(1, 0, 0, 0, 0, 0);          expect_state("ret_tgt", 11'h011, 0);
        step(1, 0, 0, 0, 0, 0);          expect_state("ret_nxt", 11'h012, 1);

        // Three nested calls overflow the 2-entry stack.
        step(1, 0, 2, 9'h080, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 9'h0A0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 9'h0C0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0); step(1, 0, 0, 0, 0, 0); expect_state("nest_r1", 11'h0A1, 0);
        step(1, 0, 3, 0, 0, 0); step(1, 0, 0, 0, 0, 0); expect_state("nest_r2", 11'h081, 0);
        step(1, 0, 3, 0, 0, 0); step(1, 0, 0, 0, 0, 0); expect_state("nest_r3", 11'h081, 0);

        goto_valid(11'h0FF);
        step(1, 0, 5, 0, 0, 0);          expect_state("skip_at", 11'h0FF, 1);
        step(1, 0, 4, 0, 1, 8'hFE);      expect_state("skip_tgt", 11'h100, 0);
        step(1, 0, 4, 0, 1, 8'hFE);      expect_state("wrpcl_at", 11'h101, 1);
        step(1, 0, 0, 0, 0, 0);          expect_state("wrpcl_tgt", 11'h2FE, 0);
        step(1, 0, 0, 0, 0, 0);          expect_state("wrpcl_nxt", 11'h2FF, 1);

        // Stall across a pending flush, then reset during a CALL.
        step(1, 0, 1, 9'h055, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2, 9'h033, 0, 0); expect_state("stall", 11'h055, 0);
            check("stall_cmd", 32'(last_cmd), 32'(STK_NOP));
        end
        step(1, 0, 0, 0, 0, 0);          expect_state("unstall", 11'h055, 0);
        step(1, 1, 2, 9'h033, 0, 0);     expect_state("rst_call", 11'h056, 1);
        check("rst_call_cmd", 32'(last_cmd), 32'(STK_NOP));
        step(1, 0, 0, 0, 0, 0);          expect_state("rst_after", 11'h7FF, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 9'h033, 0, 0);
        check("rst_stall_cmd", 32'(last_cmd), 32'(STK_NOP));
        step(1, 0, 0, 0, 0, 0);          expect_state("rst_stall", 11'h7FF, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator for the PIC16C5x core. It holds the fetch PC and computes the next PC from the decoder's control-flow request: sequential, GOTO, CALL, RETLW, PCL write and skip. It drives the 2-level return stack directly, pushing return addresses and popping on RETLW. It also produces the fetch/execute pipeline flush flag that turns the instruction after a taken branch into a NOP.

## Interface
Parameters:
- `PC_WIDTH` (`PC_WIDTH` from define.v, 11): program counter width; must be ≥10.
- `RESET_VECTOR` (all ones, 11'h7FF): PC value loaded at reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: instruction-cycle enable; 0 = stall.
- `pc_op` input 3: control-flow request from the decoder (PC_OP_* encoding).
- `k` input 9: instruction literal (GOTO uses [8:0]; CALL uses [7:0]).
- `pa` input 2: STATUS[6:5] page-select bits.
- `pcl_data` input 8: ALU result for PCL writes.
- `stk_top` input PC_WIDTH: top-of-stack from the stack block (combinational).
- `pc` output PC_WIDTH: fetch address to program memory; registered.
- `inst_valid` output 1: the instruction now in the execute stage is real; registered.
- `stk_cmd` output 2: STK_PUSH / STK_POP / STK_NOP to the stack; combinational.
- `stk_data` output PC_WIDTH: return address to push, equal to `pc`.

## Operation
- Two-stage pipeline. `pc` addresses the instruction being fetched. The executing instruction sits at `pc-1` (mod 2^PC_WIDTH).
- `pc_op` is honoured only when `en=1` and `inst_valid=1`. Otherwise it is treated as PC_OP_NEXT and `stk_cmd=STK_NOP`.
- Next-PC rules, with all increments wrapping mod 2^PC_WIDTH:
  - PC_OP_NEXT (0): `pc+1`.
  - PC_OP_GOTO (1): `{pa, k[8:0]}`. Taken.
  - PC_OP_CALL (2): `{pa, 1'b0, k[7:0]}`. Drive `stk_cmd=STK_PUSH` with `stk_data=pc`. Taken.
  - PC_OP_RET (3): `stk_top`. Drive `stk_cmd=STK_POP`. Taken.
  - PC_OP_WRPCL (4): `{pa, 1'b0, pcl_data}`. Taken.
  - PC_OP_SKIP (5): `pc+1`. Taken, so the flush discards the fetched instruction.
  - Codes 6–7 behave as NEXT.
- For PC_WIDTH >10, bits above 10 are 0 in the GOTO, CALL and WRPCL targets.
- Flush: a taken op sets `inst_valid<=0` for exactly one enabled cycle. Any other enabled cycle sets `inst_valid<=1`.
- Stall (`en=0`): `pc` and `inst_valid` hold, and `stk_cmd=STK_NOP`.
- Stack overflow and underflow are not detected. The stack wraps silently, matching the silicon.

## Timing
- Reset, sampled on the edge: `pc<=RESET_VECTOR`, `inst_valid<=0`. `stk_cmd=STK_NOP` while `rst=1`.
- First enabled cycle after reset: `pc=7FF`, `inst_valid=0`.
- Next enabled cycle: `pc=000`, `inst_valid=1`; the instruction at 7FF executes.
- A taken op in cycle n:
  - `pc` holds the target in cycle n+1, with `inst_valid=0`.
  - The target instruction executes in cycle n+2.
  - Every branch therefore costs 2 instruction cycles.
- PUSH and POP are presented in the same cycle as the CALL or RET executes. The stack commits them on that cycle's edge.
- RET selects `stk_top` combinationally before the pop edge, so no bypass is needed.
- Reset asserted mid-branch or mid-stall overrides everything. The PUSH or POP from that cycle is suppressed.
- `rst` together with `en=0`: reset still wins.

## Structure
- define.v (shared) gains:
  - `PC_OP_NEXT/GOTO/CALL/RET/WRPCL/SKIP` (3-bit).
  - `RESET_VECTOR`.
- It reuses the existing `STK_PUSH/STK_POP/STK_NOP` and `PC_WIDTH`.
- No sub-module. `pc_gen` is instantiated next to `stack` in the core top, with `stk_cmd`→`commandIn`, `stk_data`→`in` and `topOut`→`stk_top`.

## Test plan
- Reset release with `en=1`, NEXT ops → `pc` sequence 7FF, 000, 001, 002; `inst_valid` 0, 1, 1, 1.
- Execute GOTO at fetch `pc=005` with `k=9'h123`, `pa=2'b10` → next `pc=523`, `inst_valid=0` for one cycle, then 524 with `inst_valid=1`.
- CALL at `pc=011` with `k=8'h40`, `pa=0`, then RET at the callee → PUSH of 011 in the CALL cycle, `pc=040`; RET drives POP and returns `pc=011`, followed by one flush cycle.
- Nested CALL ×3 then RET ×3 → the third push overwrites the oldest entry; returns are addr3, addr2, addr2 (wrap behaviour).
- SKIP at `pc=0FF`, then WRPCL with `pcl_data=8'hFE`, `pa=1` → `pc` 100 with flush, then 2FE with flush.
- Apply `en=0` for 3 cycles during a pending flush, then assert `rst` during a CALL → state holds during the stall; reset gives `pc=7FF`, `inst_valid=0` and no PUSH.
